bus_datapath_seq: RTL and testbench
===================================

# bus_datapath_seq

Parametrised successor to the single-bus CPU datapath. It holds an NREGS × DATA_W general register file, Y/Z ALU staging registers, and MAR/MDR, all joined by one shared internal bus. A built-in T-state sequencer executes one command at a time through a valid/ready command port, and talks to external memory through a req/ack handshake. Its upstream is the instruction-decode stage; its downstream is the RAM controller and the output port.

## Interface
Parameters:
- DATA_W, 32, width of registers, bus, ALU and memory data/address
- NREGS, 16, number of general registers (power of two, ≥2)
- RA_W, 4, register-index width, must equal log2(NREGS)

Ports:
- clk  in  1  single clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LOAD, 6 STORE, 7 OUT
- cmd_ra, cmd_rb, cmd_rc  in  RA_W each  destination/data reg, source/base reg, second source
- cmd_imm  in  DATA_W  immediate/offset
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  DATA_W  driven from MAR
- mem_wdata  out  DATA_W  driven from MDR
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe
- done  out  1  one-cycle pulse when a command retires
- err  out  1  qualifies done; reserved op under DP_OUTPORT_EN absent
- result  out  DATA_W  last value written to register/port or memory
- out_port  out  DATA_W  output port register

## Operation
- States: IDLE, T1, T2, T3, MEM, WB.
- cmd_ready = (state==IDLE). Command fields are latched on the accepting edge; later changes on the inputs are ignored.
- T1: Y ← R[rb]. For ADDI/LOAD/STORE, an rb of 0 reads as zero (base-address masking); elsewhere R0 is an ordinary register.
- T2: Z ← ALU(Y, B), where B = R[rc] for ADD/SUB/AND/OR and cmd_imm for ADDI/LOAD/STORE.
  - Arithmetic wraps modulo 2^DATA_W.
  - SUB computes Y−B.
  - OUT passes Z ← R[ra].
- T3:
  - ALU ops: R[ra] ← Z, done, go to IDLE.
  - LOAD/STORE: MAR ← Z. STORE also does MDR ← R[ra]. Go to MEM.
  - OUT: out_port ← Z, done, go to IDLE.
- MEM: mem_req=1, with mem_we=1 for STORE.
  - On an edge with mem_ack=1: LOAD does MDR ← mem_rdata and goes to WB. STORE raises done and goes to IDLE.
  - mem_ack outside MEM is ignored.
- WB: R[ra] ← MDR, done, go to IDLE.
- result updates on the same edge as done, with the written value. For STORE it takes MDR.
- A write to the register currently being read in the same command (e.g., ADD r3,r3,r3) uses the pre-write value.

## Timing
- Reset values: every register, Y, Z, MAR, MDR, out_port, result = 0. State = IDLE, cmd_ready=1, mem_req=mem_we=done=err=0.
- clr asserted mid-command, including in MEM, aborts it immediately: mem_req drops asynchronously and no done is issued.
- Let the accepting edge be k.
  - ALU/ADDI/OUT: write and done take effect at edge k+3.
  - LOAD: write and done at k+5+w.
  - STORE: done at k+4+w.
  - w = number of MEM cycles before mem_ack is sampled high.
- done is registered, so it is high for the cycle following the retiring edge. cmd_ready is also high in that cycle, so the earliest next accept is edge k+4 for ALU ops.
- mem_addr and mem_wdata are stable for the whole time mem_req is high.

## Configuration
- DP_OUTPORT_EN defined:
  - op 7 (OUT) loads out_port from R[ra] at k+3.
  - err is never asserted.
- DP_OUTPORT_EN undefined:
  - out_port is tied to 0.
  - op 7 goes IDLE→T1→T2→T3 with no state change and retires at k+3 with done=1, err=1.
  - result is unchanged.

## Test plan
- Reset, then ADDI r1,r0,0x10 and ADDI r2,r0,0xFFFFFFFF, then ADD r3,r1,r2 → r3=0x0000000F, done exactly 3 cycles after each accept, err=0.
- SUB r4,r1,r3 with r1=0x10, r3=0x0F → r4=0x1; AND/OR on 0xF0F0/0x0FF0 → 0x00F0 / 0xFFF0.
- STORE r3 to [r1+4], memory model acks after 2 wait cycles → mem_addr=0x14, mem_wdata=0x0F, mem_we=1, req held 3 cycles, done at k+6. Then LOAD r5,[r1+4] → r5=0x0F at k+7.
- LOAD with rb=0 and imm=0x20, while r0 holds 0xDEAD → mem_addr=0x20.
- Assert clr while in MEM with ack withheld → mem_req falls the same cycle, no done, all registers read 0, cmd_ready=1.
- OUT r3: with DP_OUTPORT_EN → out_port=0x0F, err=0. Without it → out_port=0, done with err=1.

Source files
------------

// File: rtl/bus_datapath_seq.sv
// Single-bus CPU datapath with a T-state sequencer, valid/ready command port and req/ack memory port.
// Optional OUT port: define DP_OUTPORT_EN to enable op 7; otherwise op 7 retires with err=1.
module bus_datapath_seq #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [RA_W-1:0]   cmd_ra,
  input  logic [RA_W-1:0]   cmd_rb,
  input  logic [RA_W-1:0]   cmd_rc,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] out_port
);

`ifdef DP_OUTPORT_EN
  localparam bit OUT_EN = 1'b1;
`else
  localparam bit OUT_EN = 1'b0;
`endif

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_ADDI  = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;
  localparam logic [2:0] OP_STORE = 3'd6;
  localparam logic [2:0] OP_OUT   = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_MEM, S_WB} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [RA_W-1:0]   ra_reg, rb_reg, rc_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] y_reg, z_reg, mar_reg, mdr_reg, out_reg, result_reg;
  logic              done_reg, err_reg;

  logic [RA_W-1:0]   rd_addr;
  logic [DATA_W-1:0] rd_data, bus_data, alu_out, wr_data;
  logic              uses_imm, op_live, wr_en;

  assign uses_imm = (op_reg == OP_ADDI) || (op_reg == OP_LOAD) || (op_reg == OP_STORE);
  // A disabled OUT op walks the T-states without touching any datapath register.
  assign op_live  = OUT_EN || (op_reg != OP_OUT);

  always_comb begin
    rd_addr = rb_reg;
    case (state_reg)
      S_T2:    rd_addr = (op_reg == OP_OUT) ? ra_reg : rc_reg;
      S_T3:    rd_addr = ra_reg;
      default: rd_addr = rb_reg;
    endcase
  end

  assign rd_data = regs[rd_addr];

  // The shared internal bus: base in T1, second operand in T2, store data in T3.
  always_comb begin
    bus_data = rd_data;
    case (state_reg)
      S_T1:    bus_data = (uses_imm && (rb_reg == '0)) ? '0 : rd_data;
      S_T2:    bus_data = uses_imm ? imm_reg : rd_data;
      default: bus_data = rd_data;
    endcase
  end

  always_comb begin
    alu_out = bus_data;
    case (op_reg)
      OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: alu_out = y_reg + bus_data;
      OP_SUB:  alu_out = y_reg - bus_data;
      OP_AND:  alu_out = y_reg & bus_data;
      OP_OR:   alu_out = y_reg | bus_data;
      default: alu_out = bus_data;
    endcase
  end

  assign wr_en   = ((state_reg == S_T3) && (op_reg <= OP_ADDI)) || (state_reg == S_WB);
  assign wr_data = (state_reg == S_WB) ? mdr_reg : z_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (cmd_valid) state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3:    state_next = ((op_reg == OP_LOAD) || (op_reg == OP_STORE)) ? S_MEM : S_IDLE;
      S_MEM:   if (mem_ack) state_next = (op_reg == OP_LOAD) ? S_WB : S_IDLE;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[ra_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_reg     <= '0;
      ra_reg     <= '0;
      rb_reg     <= '0;
      rc_reg     <= '0;
      imm_reg    <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      mar_reg    <= '0;
      mdr_reg    <= '0;
      out_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            op_reg  <= cmd_op;
            ra_reg  <= cmd_ra;
            rb_reg  <= cmd_rb;
            rc_reg  <= cmd_rc;
            imm_reg <= cmd_imm;
          end
        end
        S_T1: if (op_live) y_reg <= bus_data;
        S_T2: if (op_live) z_reg <= alu_out;
        S_T3: begin
          if (op_reg <= OP_ADDI) begin
            done_reg   <= 1'b1;
            result_reg <= z_reg;
          end else if ((op_reg == OP_LOAD) || (op_reg == OP_STORE)) begin
            mar_reg <= z_reg;
            if (op_reg == OP_STORE) mdr_reg <= bus_data;
          end else begin
            done_reg <= 1'b1;
            if (OUT_EN) begin
              out_reg    <= z_reg;
              result_reg <= z_reg;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op_reg == OP_LOAD) begin
              mdr_reg <= mem_rdata;
            end else begin
              done_reg   <= 1'b1;
              result_reg <= mdr_reg;
            end
          end
        end
        S_WB: begin
          done_reg   <= 1'b1;
          result_reg <= mdr_reg;
        end
        default: ;
      endcase
    end
  end

  // mem_req follows the state register, so clr removes it without waiting for an edge.
  assign cmd_ready = (state_reg == S_IDLE);
  assign mem_req   = (state_reg == S_MEM);
  assign mem_we    = mem_req && (op_reg == OP_STORE);
  assign mem_addr  = mar_reg;
  assign mem_wdata = mdr_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign result    = result_reg;
  assign out_port  = out_reg;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed self-checking bench for bus_datapath_seq with a small wait-state memory model.
module tb_bus_datapath_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_ra = '0, cmd_rb = '0, cmd_rc = '0;
  logic [31:0] cmd_imm = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack = 1'b0;
  logic        done, err;
  logic [31:0] result, out_port;

  int checks = 0;
  int failures = 0;

  // memory model state
  logic [31:0] mem_model [256] = '{default: 32'h0};
  logic        mem_valid [256] = '{default: 1'b0};
  int          ack_wait = 0;
  logic        withhold = 1'b0;
  int          mem_cnt = 0;
  int          req_cycles = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic        cap_we = 1'b0;
  logic        unstable = 1'b0;

  int          lat_v;
  logic [31:0] res_v;
  logic        err_v;

  bus_datapath_seq #(.DATA_W(32), .NREGS(16), .RA_W(4)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc), .cmd_imm(cmd_imm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .done(done), .err(err), .result(result), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Unwritten locations return a recognisable address-derived pattern.
  assign mem_rdata = mem_valid[mem_addr[7:0]] ? mem_model[mem_addr[7:0]]
                                              : {16'hA5A5, 8'h00, mem_addr[7:0]};

  always @(negedge clk) begin
    if (mem_req) begin
      if (mem_cnt == 0) begin
        cap_addr   = mem_addr;
        cap_wdata  = mem_wdata;
        cap_we     = mem_we;
        req_cycles = 0;
      end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata) begin
        unstable = 1'b1;
      end
      req_cycles++;
      if (!withhold && mem_cnt == ack_wait) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_model[mem_addr[7:0]] = mem_wdata;
          mem_valid[mem_addr[7:0]] = 1'b1;
        end
      end else begin
        mem_ack = 1'b0;
      end
      mem_cnt++;
    end else begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one command, count edges from the accepting edge to done, then confirm done is a pulse.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic [31:0] imm,
                        input int exp_lat, input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op  = 3'($urandom);
    cmd_ra  = 4'($urandom);
    cmd_rb  = 4'($urandom);
    cmd_rc  = 4'($urandom);
    cmd_imm = $urandom;
    lat_v = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      lat_v++;
      if (done === 1'b1) break;
    end
    res_v = result;
    err_v = err;
    chk({tag, "_latency"}, 32'(lat_v), 32'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int done_seen;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_done",  {30'b0, done, err}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_out",    out_port, 32'h0);
    @(negedge clk);
    clr = 1'b0;

    do_cmd(3'd4, 4'd1, 4'd0, 4'd0, 32'h10, 3, "addi_r1");
    chk("addi_r1_res", res_v, 32'h10);
    chk("addi_r1_err", {31'b0, err_v}, 32'd0);
    do_cmd(3'd4, 4'd2, 4'd0, 4'd0, 32'hFFFF_FFFF, 3, "addi_r2");
    chk("addi_r2_res", res_v, 32'hFFFF_FFFF);
    do_cmd(3'd0, 4'd3, 4'd1, 4'd2, 32'h0, 3, "add_r3");
    chk("add_r3_res", res_v, 32'h0000_000F);
    chk("add_r3_err", {31'b0, err_v}, 32'd0);
    do_cmd(3'd1, 4'd4, 4'd1, 4'd3, 32'h0, 3, "sub_r4");
    chk("sub_r4_res", res_v, 32'h1);
    do_cmd(3'd1, 4'd12, 4'd3, 4'd1, 32'h0, 3, "sub_wrap");
    chk("sub_wrap_res", res_v, 32'hFFFF_FFFF);

    do_cmd(3'd4, 4'd7, 4'd0, 4'd0, 32'hF0F0, 3, "addi_r7");
    do_cmd(3'd4, 4'd8, 4'd0, 4'd0, 32'h0FF0, 3, "addi_r8");
    do_cmd(3'd2, 4'd9, 4'd7, 4'd8, 32'h0, 3, "and_r9");
    chk("and_r9_res", res_v, 32'h0000_00F0);
    do_cmd(3'd3, 4'd10, 4'd7, 4'd8, 32'h0, 3, "or_r10");
    chk("or_r10_res", res_v, 32'h0000_FFF0);

    do_cmd(3'd4, 4'd11, 4'd0, 4'd0, 32'h5, 3, "addi_r11");
    do_cmd(3'd0, 4'd11, 4'd11, 4'd11, 32'h0, 3, "add_self");
    chk("add_self_res", res_v, 32'hA);

    ack_wait = 2;
    do_cmd(3'd6, 4'd3, 4'd1, 4'd0, 32'h4, 6, "store");
    chk("store_addr",  cap_addr, 32'h14);
    chk("store_wdata", cap_wdata, 32'h0F);
    chk("store_we",    {31'b0, cap_we}, 32'd1);
    chk("store_req_cycles", 32'(req_cycles), 32'd3);
    chk("store_res",   res_v, 32'h0F);

    do_cmd(3'd5, 4'd5, 4'd1, 4'd0, 32'h4, 7, "load");
    chk("load_addr", cap_addr, 32'h14);
    chk("load_we",   {31'b0, cap_we}, 32'd0);
    chk("load_res",  res_v, 32'h0F);
    do_cmd(3'd0, 4'd13, 4'd5, 4'd0, 32'h0, 3, "add_r5_copy");
    chk("r5_value", res_v, 32'h0F);

    ack_wait = 0;
    do_cmd(3'd4, 4'd0, 4'd0, 4'd0, 32'hDEAD, 3, "addi_r0");
    chk("addi_r0_res", res_v, 32'hDEAD);
    do_cmd(3'd5, 4'd6, 4'd0, 4'd0, 32'h20, 5, "load_base0");
    chk("load_base0_addr", cap_addr, 32'h20);
    chk("load_base0_res",  res_v, 32'hA5A5_0020);
    do_cmd(3'd0, 4'd14, 4'd0, 4'd1, 32'h0, 3, "add_r0_plain");
    chk("add_r0_plain_res", res_v, 32'h0000_DEBD);

`ifdef DP_OUTPORT_EN
    do_cmd(3'd7, 4'd3, 4'd0, 4'd0, 32'h0, 3, "out");
    chk("out_port", out_port, 32'h0F);
    chk("out_err",  {31'b0, err_v}, 32'd0);
    chk("out_res",  res_v, 32'h0F);
`else
    do_cmd(3'd7, 4'd3, 4'd0, 4'd0, 32'h0, 3, "out");
    chk("out_port", out_port, 32'h0);
    chk("out_err",  {31'b0, err_v}, 32'd1);
    chk("out_res",  res_v, 32'h0000_DEBD);
`endif

    chk("mem_stable", {31'b0, unstable}, 32'd0);

    // Abort a STORE while it waits in MEM.
    withhold = 1'b1;
    @(negedge clk);
    cmd_op = 3'd6; cmd_ra = 4'd3; cmd_rb = 4'd1; cmd_imm = 32'h0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req === 1'b1) break;
      @(posedge clk);
      #1;
    end
    chk("abort_req_seen", {31'b0, mem_req}, 32'd1);
    #2;
    clr = 1'b1;
    #1;
    chk("abort_req_drop", {31'b0, mem_req}, 32'd0);
    chk("abort_ready",    {31'b0, cmd_ready}, 32'd1);
    chk("abort_result",   result, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    withhold = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    do_cmd(3'd6, 4'd3, 4'd1, 4'd0, 32'h8, 4, "post_clr_store");
    chk("post_clr_addr",  cap_addr, 32'h8);
    chk("post_clr_wdata", cap_wdata, 32'h0);
    do_cmd(3'd0, 4'd6, 4'd2, 4'd13, 32'h0, 3, "post_clr_add");
    chk("post_clr_add_res", res_v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
